// File: rtl/deglitch_pkg.sv
// Shared constants and helpers for the deglitch/synchroniser bank.
package deglitch_pkg;

    // Default, minimum and maximum values of the bank parameters
    localparam int NCH_DEF  = 4;
    localparam int NCH_MIN  = 1;
    localparam int NCH_MAX  = 32;
    localparam int SYNC_DEF = 2;
    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;
    localparam int DEB_DEF  = 4;
    localparam int DEB_MIN  = 1;
    localparam int DEB_MAX  = 255;

    // Width of a per-channel stability counter that must hold 0..deb_cycles
    function automatic int cnt_width(input int deb_cycles);
        return $clog2(deb_cycles + 1);
    endfunction

endpackage

// File: rtl/deglitch_chan.sv
// One channel: synchroniser chain, stability counter, debounced level and
// registered edge pulses.
module deglitch_chan
    import deglitch_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_DEF,
    parameter int   DEB_CYCLES  = DEB_DEF,
    parameter logic INIT_BIT    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    input  logic en,
    input  logic clr,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam int             CW       = cnt_width(DEB_CYCLES);
    // Counter value at which the next differing sample commits the new level
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   q_q, q_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain shifts every cycle, independent of en and clr
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{INIT_BIT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    // Debounce decision: clear wins over enable, pulses only on a qualified change
    always_comb begin
        cnt_d  = cnt_q;
        q_d    = q_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
            q_d   = INIT_BIT;
        end else if (en) begin
            if (s == q_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                q_d    = s;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Counter, debounced level and pulse registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            q_q    <= INIT_BIT;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/deglitch_sync_bank.sv
// Bank of NCH independent synchronise-and-debounce channels.
module deglitch_sync_bank
    import deglitch_pkg::*;
#(
    parameter int             NCH         = NCH_DEF,
    parameter int             SYNC_STAGES = SYNC_DEF,
    parameter int             DEB_CYCLES  = DEB_DEF,
    parameter logic [NCH-1:0] INIT_VAL    = {NCH{1'b0}}
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] d,
    input  logic           en,
    input  logic           clr,
    output logic [NCH-1:0] q,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall
);

    // Reject out-of-range configurations at elaboration
    if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
        $error("deglitch_sync_bank: NCH=%0d outside %0d..%0d", NCH, NCH_MIN, NCH_MAX);
    end
    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $error("deglitch_sync_bank: SYNC_STAGES=%0d outside %0d..%0d", SYNC_STAGES, SYNC_MIN, SYNC_MAX);
    end
    if (DEB_CYCLES < DEB_MIN || DEB_CYCLES > DEB_MAX) begin : g_bad_deb
        $error("deglitch_sync_bank: DEB_CYCLES=%0d outside %0d..%0d", DEB_CYCLES, DEB_MIN, DEB_MAX);
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        deglitch_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES),
            .INIT_BIT    (INIT_VAL[i])
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .d     (d[i]),
            .en    (en),
            .clr   (clr),
            .q     (q[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_deglitch_sync_bank.sv
// Self-checking bench for deglitch_sync_bank: directed vector table, corner
// sequences and randomized traffic against a behavioural model.
module tb_deglitch_sync_bank;

    localparam int             NCH  = 4;
    localparam int             SS   = 2;
    localparam int             DEB  = 4;
    localparam logic [NCH-1:0] INIT = 4'h0;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] d;
    logic           en;
    logic           clr;
    logic [NCH-1:0] q, rise, fall;

    int total = 0;
    int bad   = 0;

    deglitch_sync_bank #(
        .NCH         (NCH),
        .SYNC_STAGES (SS),
        .DEB_CYCLES  (DEB),
        .INIT_VAL    (INIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .en    (en),
        .clr   (clr),
        .q     (q),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clk = ~clk;

    // Behavioural model: s is d delayed by SS sampled edges; a channel takes
    // the new level once s has differed from q for DEB consecutive enabled edges.
    logic [NCH-1:0] m_hist[$];
    logic [NCH-1:0] m_q, m_rise, m_fall;
    int             m_run[NCH];

    task automatic model_reset();
        m_hist.delete();
        for (int k = 0; k < SS; k++) m_hist.push_back(INIT);
        m_q    = INIT;
        m_rise = '0;
        m_fall = '0;
        for (int c = 0; c < NCH; c++) m_run[c] = 0;
    endtask

    task automatic model_edge();
        logic [NCH-1:0] s;
        s      = m_hist[0];
        m_rise = '0;
        m_fall = '0;
        if (clr) begin
            m_q = INIT;
            for (int c = 0; c < NCH; c++) m_run[c] = 0;
        end else if (en) begin
            for (int c = 0; c < NCH; c++) begin
                if (s[c] == m_q[c]) begin
                    m_run[c] = 0;
                end else begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == DEB) begin
                        m_q[c]    = s[c];
                        m_rise[c] = s[c];
                        m_fall[c] = ~s[c];
                        m_run[c]  = 0;
                    end
                end
            end
        end
        void'(m_hist.pop_front());
        m_hist.push_back(d);
    endtask

    task automatic chk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string name);
        chk({name, ".q"},    q,    m_q);
        chk({name, ".rise"}, rise, m_rise);
        chk({name, ".fall"}, fall, m_fall);
        chk({name, ".excl"}, rise & fall, '0);
    endtask

    // One clock edge; model follows, outputs sampled 1 time unit later
    task automatic tick(input string name);
        @(posedge clk);
        if (reset) model_edge();
        else       model_reset();
        #1;
        chk_model(name);
    endtask

    task automatic chk_out(input string name, input logic [NCH-1:0] eq, input logic [NCH-1:0] er,
                           input logic [NCH-1:0] ef);
        chk({name, ".q"},    q,    eq);
        chk({name, ".rise"}, rise, er);
        chk({name, ".fall"}, fall, ef);
    endtask

    typedef struct {
        logic [NCH-1:0] d;
        logic           en;
        logic           clr;
        logic [NCH-1:0] q;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // Rising edge on ch0 lands on the 6th edge; a 3-cycle glitch on ch1 is rejected
        for (int i = 0; i < 16; i++) begin
            tbl[i].en   = 1'b1;
            tbl[i].clr  = 1'b0;
            tbl[i].d    = (i < 7) ? 4'h1 : (i < 10) ? 4'h3 : 4'h1;
            tbl[i].q    = (i < 5) ? 4'h0 : 4'h1;
            tbl[i].rise = 4'h0;
            tbl[i].fall = 4'h0;
        end
        tbl[5].rise = 4'h1;

        // Reset asserted with all inputs high
        reset = 1'b0;
        d     = 4'hF;
        en    = 1'b1;
        clr   = 1'b0;
        model_reset();
        #2;
        chk_out("rst_now", 4'h0, 4'h0, 4'h0);
        tick("rst_hold1");
        tick("rst_hold2");
        d = 4'h0;
        tick("rst_hold3");
        reset = 1'b1;
        chk_out("rst_release", 4'h0, 4'h0, 4'h0);
        tick("post_rel1");
        tick("post_rel2");

        // Directed table
        for (int i = 0; i < 16; i++) begin
            d   = tbl[i].d;
            en  = tbl[i].en;
            clr = tbl[i].clr;
            tick($sformatf("tbl%0d_model", i));
            chk_out($sformatf("tbl%0d", i), tbl[i].q, tbl[i].rise, tbl[i].fall);
        end

        // ch2 counts twice, stalls 5 cycles with en low, then needs two more edges
        d = 4'h5;
        for (int k = 0; k < 4; k++) tick("en_pre");
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick("en_hold");
            chk_out("en_hold_x", 4'h1, 4'h0, 4'h0);
        end
        en = 1'b1;
        tick("en_resume1");
        chk_out("en_resume1_x", 4'h1, 4'h0, 4'h0);
        tick("en_resume2");
        chk_out("en_resume2_x", 4'h5, 4'h4, 4'h0);

        // Move to q=3, then clear: no fall pulses, level recovers after 4 edges
        d = 4'h3;
        for (int k = 0; k < 8; k++) tick("to3");
        chk_out("to3_x", 4'h3, 4'h0, 4'h0);
        clr = 1'b1;
        tick("clr");
        chk_out("clr_x", 4'h0, 4'h0, 4'h0);
        clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick("clr_after");
            chk_out("clr_after_x", 4'h0, 4'h0, 4'h0);
        end
        tick("clr_ret");
        chk_out("clr_ret_x", 4'h3, 4'h3, 4'h0);

        // Reset mid-count on ch3: immediate clear, full latency after release
        d = 4'hB;
        for (int k = 0; k < 3; k++) tick("mid_cnt");
        reset = 1'b0;
        model_reset();
        #1;
        chk_out("mid_rst_now", 4'h0, 4'h0, 4'h0);
        tick("mid_rst_hold");
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick("mid_rel");
            chk_out("mid_rel_x", 4'h0, 4'h0, 4'h0);
        end
        tick("mid_rel6");
        chk_out("mid_rel6_x", 4'hB, 4'hB, 4'h0);
        tick("mid_rel7");
        chk_out("mid_rel7_x", 4'hB, 4'h0, 4'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [NCH-1:0] flip;
            flip = '0;
            for (int c = 0; c < NCH; c++) flip[c] = ($urandom_range(0, 5) == 0);
            d   = d ^ flip;
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 59) == 0);
            if (!reset) begin
                reset = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                model_reset();
                #1;
                chk_model("rand_rst");
            end
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
